// File: rtl/fsmc_master_pkg.sv
// fsmc_master_pkg: shared FSMC bus widths, FSM state encoding and byte-mask helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fsmc_master_pkg;

   // Phase counter width; every timing parameter must fit in 1..15
   localparam int CNT_W   = 4;
   // FSMC bus widths, common to initiator and responder
   localparam int FSMC_AW = 16;
   localparam int FSMC_DW = 16;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_DATA  = 3'd2,
      ST_HOLD  = 3'd3,
      ST_TURN  = 3'd4,
      ST_ACK   = 3'd5
   } state_e;

   // Zero the bytes of a half-word whose select bit is clear
   function automatic logic [FSMC_DW-1:0] mask_half(input logic [FSMC_DW-1:0] d,
                                                    input logic [1:0]         sel);
      return {(sel[1] ? d[15:8] : 8'h00), (sel[0] ? d[7:0] : 8'h00)};
   endfunction

endpackage

// File: rtl/fsmc_phase_timer.sv
// fsmc_phase_timer: loadable down-counter that times each FSMC bus phase.
// Latency: done_o is high in the Nth cycle after a load of N (N=1 -> immediately).
// Backpressure: none; a load always takes priority over counting.
module fsmc_phase_timer
   import fsmc_master_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   output logic             done_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Load N-1 so the phase lasts exactly N cycles; otherwise count down to zero and stick
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i - 1'b1;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   // Counter register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/fsmc_master.sv
// fsmc_master: Wishbone slave that runs each 32-bit access as one or two 16-bit FSMC half-cycles.
// Latency: accept edge to ack = halves*(ADDR_SETUP+DATA_PHASE+DATA_HOLD)+TURNAROUND+1 (8/14 at defaults), sel==0 -> 1.
// Backpressure: one access in flight; a new request is taken only in IDLE with ack low, the bus side never stalls.
module fsmc_master
   import fsmc_master_pkg::*;
#(
   parameter int unsigned ADDR_SETUP = 2,
   parameter int unsigned DATA_PHASE = 3,
   parameter int unsigned DATA_HOLD  = 1,
   parameter int unsigned TURNAROUND = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [23:0]        wbs_adr_i,
   input  logic [31:0]        wbs_dat_i,
   output logic [31:0]        wbs_dat_o,
   input  logic [3:0]         wbs_sel_i,
   input  logic               wbs_cyc_i,
   input  logic               wbs_stb_i,
   input  logic               wbs_we_i,
   output logic               wbs_ack_o,
   output logic [FSMC_AW-1:0] fsmc_a,
   output logic [FSMC_DW-1:0] fsmc_d_o,
   input  logic [FSMC_DW-1:0] fsmc_d_i,
   output logic               fsmc_d_oe,
   output logic               fsmc_ce_n,
   output logic               fsmc_we_n,
   output logic               fsmc_oe_n,
   output logic               fsmc_ub_n,
   output logic               fsmc_lb_n
);

   // Phase lengths must fit the 4-bit timer and be non-zero
   if (ADDR_SETUP < 1 || ADDR_SETUP > 15 || DATA_PHASE < 1 || DATA_PHASE > 15 ||
       DATA_HOLD  < 1 || DATA_HOLD  > 15 || TURNAROUND < 1 || TURNAROUND > 15) begin : g_bad_timing
      $error("fsmc_master: timing parameters must lie in 1..15");
   end

   // Only the halfword index within the 128 KiB window reaches the bus
   logic unused_adr;
   assign unused_adr = ^{wbs_adr_i[23:17], wbs_adr_i[1:0]};

   // Control state
   state_e      state_q, state_d;
   logic [14:0] adr_q, adr_d;
   logic [31:0] dat_q, dat_d;
   logic [3:0]  sel_q, sel_d;
   logic        we_q, we_d;
   logic        hi_q, hi_d;       // current half-cycle is the upper halfword
   logic        abort_q, abort_d; // cyc dropped: finish this half, skip the rest, no ack

   // Registered outputs
   logic [FSMC_AW-1:0] a_q, a_d;
   logic [FSMC_DW-1:0] d_o_q, d_o_d;
   logic               d_oe_q, d_oe_d;
   logic               ce_n_q, ce_n_d;
   logic               we_n_q, we_n_d;
   logic               oe_n_q, oe_n_d;
   logic               ub_n_q, ub_n_d;
   logic               lb_n_q, lb_n_d;
   logic               ack_q, ack_d;
   logic [31:0]        rdat_q, rdat_d;

   logic             tmr_load, tmr_done;
   logic [CNT_W-1:0] tmr_val;
   logic             busy_d;
   logic [1:0]       sel_half_d;

   function automatic logic [CNT_W-1:0] phase_len(input state_e s);
      case (s)
         ST_SETUP: phase_len = CNT_W'(ADDR_SETUP);
         ST_DATA:  phase_len = CNT_W'(DATA_PHASE);
         ST_HOLD:  phase_len = CNT_W'(DATA_HOLD);
         ST_TURN:  phase_len = CNT_W'(TURNAROUND);
         default:  phase_len = CNT_W'(1);
      endcase
   endfunction

   // Every state change restarts the phase timer with the new state's length
   assign tmr_load = (state_d != state_q);
   assign tmr_val  = phase_len(state_d);

   fsmc_phase_timer u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   // State and request latches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         we_q    <= 1'b0;
         hi_q    <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         we_q    <= we_d;
         hi_q    <= hi_d;
         abort_q <= abort_d;
      end
   end

   // Next state: accept, walk the phases per half, drop the high half on abort
   always_comb begin
      state_d = state_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      we_d    = we_q;
      hi_d    = hi_q;
      abort_d = abort_q;

      if (state_q != ST_IDLE && state_q != ST_ACK && !wbs_cyc_i) begin
         abort_d = 1'b1;
      end

      unique case (state_q)
         ST_IDLE: begin
            if (wbs_cyc_i && wbs_stb_i && !ack_q) begin
               adr_d   = wbs_adr_i[16:2];
               dat_d   = wbs_dat_i;
               sel_d   = wbs_sel_i;
               we_d    = wbs_we_i;
               abort_d = 1'b0;
               hi_d    = (wbs_sel_i[1:0] == 2'b00);
               state_d = (wbs_sel_i == 4'h0) ? ST_ACK : ST_SETUP;
            end
         end
         ST_SETUP: if (tmr_done) state_d = ST_DATA;
         ST_DATA:  if (tmr_done) state_d = ST_HOLD;
         ST_HOLD: begin
            if (tmr_done) begin
               if (!hi_q && sel_q[3:2] != 2'b00 && !abort_d) begin
                  hi_d    = 1'b1;
                  state_d = ST_SETUP;
               end else begin
                  state_d = ST_TURN;
               end
            end
         end
         ST_TURN:  if (tmr_done) state_d = abort_d ? ST_IDLE : ST_ACK;
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Outputs follow the next state so pins change on the same edge as the FSM
   always_comb begin
      busy_d     = (state_d == ST_SETUP) || (state_d == ST_DATA) || (state_d == ST_HOLD);
      sel_half_d = hi_d ? sel_d[3:2] : sel_d[1:0];

      a_d   = a_q;
      d_o_d = d_o_q;
      if (busy_d) begin
         a_d = {adr_d, hi_d};
         if (we_d) begin
            d_o_d = hi_d ? dat_d[31:16] : dat_d[15:0];
         end
      end

      ce_n_d = !busy_d;
      d_oe_d = busy_d && we_d;
      we_n_d = !(state_d == ST_DATA && we_d);
      oe_n_d = !(state_d == ST_DATA && !we_d);
      ub_n_d = !(busy_d && sel_half_d[1]);
      lb_n_d = !(busy_d && sel_half_d[0]);
      ack_d  = (state_q == ST_ACK);

      // Sample on the edge that ends the last DATA cycle; a low-half capture clears the upper half
      rdat_d = rdat_q;
      if (state_q == ST_DATA && tmr_done && !we_q) begin
         if (hi_q) begin
            rdat_d = {mask_half(fsmc_d_i, sel_q[3:2]),
                      (sel_q[1:0] != 2'b00) ? rdat_q[15:0] : 16'h0000};
         end else begin
            rdat_d = {16'h0000, mask_half(fsmc_d_i, sel_q[1:0])};
         end
      end
   end

   // Output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         d_o_q  <= '0;
         d_oe_q <= 1'b0;
         ce_n_q <= 1'b1;
         we_n_q <= 1'b1;
         oe_n_q <= 1'b1;
         ub_n_q <= 1'b1;
         lb_n_q <= 1'b1;
         ack_q  <= 1'b0;
         rdat_q <= '0;
      end else begin
         a_q    <= a_d;
         d_o_q  <= d_o_d;
         d_oe_q <= d_oe_d;
         ce_n_q <= ce_n_d;
         we_n_q <= we_n_d;
         oe_n_q <= oe_n_d;
         ub_n_q <= ub_n_d;
         lb_n_q <= lb_n_d;
         ack_q  <= ack_d;
         rdat_q <= rdat_d;
      end
   end

   assign fsmc_a    = a_q;
   assign fsmc_d_o  = d_o_q;
   assign fsmc_d_oe = d_oe_q;
   assign fsmc_ce_n = ce_n_q;
   assign fsmc_we_n = we_n_q;
   assign fsmc_oe_n = oe_n_q;
   assign fsmc_ub_n = ub_n_q;
   assign fsmc_lb_n = lb_n_q;
   assign wbs_ack_o = ack_q;
   assign wbs_dat_o = rdat_q;

endmodule

// File: tb/tb_fsmc_master.sv
// tb_fsmc_master: directed Wishbone accesses against a behavioural FSMC responder.
// Latency: measured from the accept edge to the first cycle ack is seen high.
// Backpressure: the bench holds cyc/stb until ack or a fixed cycle budget expires.
module tb_fsmc_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [23:0] wbs_adr_i = '0;
   logic [31:0] wbs_dat_i = '0;
   logic [31:0] wbs_dat_o;
   logic [3:0]  wbs_sel_i = '0;
   logic        wbs_cyc_i = 1'b0;
   logic        wbs_stb_i = 1'b0;
   logic        wbs_we_i  = 1'b0;
   logic        wbs_ack_o;
   logic [15:0] fsmc_a, fsmc_d_o, fsmc_d_i;
   logic        fsmc_d_oe, fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n;

   always #5 clk = ~clk;

   fsmc_master dut (
      .clk       (clk),
      .rst       (rst),
      .wbs_adr_i (wbs_adr_i),
      .wbs_dat_i (wbs_dat_i),
      .wbs_dat_o (wbs_dat_o),
      .wbs_sel_i (wbs_sel_i),
      .wbs_cyc_i (wbs_cyc_i),
      .wbs_stb_i (wbs_stb_i),
      .wbs_we_i  (wbs_we_i),
      .wbs_ack_o (wbs_ack_o),
      .fsmc_a    (fsmc_a),
      .fsmc_d_o  (fsmc_d_o),
      .fsmc_d_i  (fsmc_d_i),
      .fsmc_d_oe (fsmc_d_oe),
      .fsmc_ce_n (fsmc_ce_n),
      .fsmc_we_n (fsmc_we_n),
      .fsmc_oe_n (fsmc_oe_n),
      .fsmc_ub_n (fsmc_ub_n),
      .fsmc_lb_n (fsmc_lb_n)
   );

   // Responder: data is valid only from the third cycle of oe_n low, garbage before
   int          oe_run = 0;
   logic [15:0] rsp_lo = 16'h0000;
   logic [15:0] rsp_hi = 16'h0000;
   always @(posedge clk) oe_run <= fsmc_oe_n ? 0 : oe_run + 1;
   assign fsmc_d_i = (!fsmc_oe_n && oe_run >= 2) ? (fsmc_a[0] ? rsp_hi : rsp_lo) : 16'hEEEE;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus monitor state for one transaction
   int          we_lo, oe_lo, ce_lo, doe_cnt, nstr, lat;
   bit          got_ack, prev_str;
   logic [15:0] mon_a [4];
   logic [15:0] mon_d [4];
   logic        mon_ub [4];
   logic        mon_lb [4];

   task automatic sample();
      logic str;
      str = !fsmc_we_n || !fsmc_oe_n;
      if (!fsmc_we_n) we_lo++;
      if (!fsmc_oe_n) oe_lo++;
      if (!fsmc_ce_n) ce_lo++;
      if (fsmc_d_oe)  doe_cnt++;
      if (str && !prev_str && nstr < 4) begin
         mon_a[nstr]  = fsmc_a;
         mon_d[nstr]  = fsmc_d_o;
         mon_ub[nstr] = fsmc_ub_n;
         mon_lb[nstr] = fsmc_lb_n;
         nstr++;
      end
      prev_str = str;
   endtask

   task automatic mon_clear();
      we_lo = 0; oe_lo = 0; ce_lo = 0; doe_cnt = 0; nstr = 0;
      lat = -1; got_ack = 1'b0; prev_str = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mon_a[i] = 'x; mon_d[i] = 'x; mon_ub[i] = 1'bx; mon_lb[i] = 1'bx;
      end
   endtask

   // One access over a fixed 40-cycle window; drop_at > 0 releases cyc after that sample
   task automatic xfer(input logic [23:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input int drop_at);
      mon_clear();
      wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         sample();
         if (wbs_ack_o) begin
            if (!got_ack) lat = c - 1;
            got_ack   = 1'b1;
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
         end
         if (c == drop_at) begin
            wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
         end
      end
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", {fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n}, 5'b11111);
      check("rst_a", fsmc_a, 16'h0000);
      check("rst_d_o", fsmc_d_o, 16'h0000);
      check("rst_d_oe", fsmc_d_oe, 1'b0);
      check("rst_ack", wbs_ack_o, 1'b0);
      check("rst_dat_o", wbs_dat_o, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;

      // Word write
      xfer(24'h000010, 32'hDEADBEEF, 4'hF, 1'b1, 0);
      check("ww_lat", lat, 14);
      check("ww_nstr", nstr, 2);
      check("ww_a0", mon_a[0], 16'h0008);
      check("ww_d0", mon_d[0], 16'hBEEF);
      check("ww_a1", mon_a[1], 16'h0009);
      check("ww_d1", mon_d[1], 16'hDEAD);
      check("ww_we_lo", we_lo, 6);
      check("ww_ublb", {mon_ub[0], mon_lb[0], mon_ub[1], mon_lb[1]}, 4'b0000);
      check("ww_ce_lo", ce_lo, 12);
      check("ww_oe_lo", oe_lo, 0);

      // Word read
      rsp_lo = 16'h1234; rsp_hi = 16'h5678;
      xfer(24'h000020, 32'h0, 4'hF, 1'b0, 0);
      check("wr_lat", lat, 14);
      check("wr_dat", wbs_dat_o, 32'h56781234);
      check("wr_oe_lo", oe_lo, 6);
      check("wr_doe", doe_cnt, 0);
      check("wr_a0", mon_a[0], 16'h0010);
      check("wr_a1", mon_a[1], 16'h0011);
      check("wr_we_lo", we_lo, 0);

      // Byte write in the upper half only
      xfer(24'h000010, 32'h00AB0000, 4'h4, 1'b1, 0);
      check("bw_lat", lat, 8);
      check("bw_nstr", nstr, 1);
      check("bw_a", mon_a[0], 16'h0009);
      check("bw_d", mon_d[0], 16'h00AB);
      check("bw_ublb", {mon_ub[0], mon_lb[0]}, 2'b10);
      check("bw_we_lo", we_lo, 3);

      // Empty select: ack with no bus activity
      xfer(24'h000010, 32'h12345678, 4'h0, 1'b1, 0);
      check("s0_lat", lat, 1);
      check("s0_ce_lo", ce_lo, 0);
      check("s0_nstr", nstr, 0);

      // Single-byte read in the lower half: other bytes read as zero
      xfer(24'h000020, 32'h0, 4'h2, 1'b0, 0);
      check("br_lat", lat, 8);
      check("br_dat", wbs_dat_o, 32'h00001200);
      check("br_ublb", {mon_ub[0], mon_lb[0]}, 2'b01);

      // cyc dropped during low-half DATA of a word write
      xfer(24'h000010, 32'hCAFEF00D, 4'hF, 1'b1, 3);
      check("ab_ack", got_ack, 1'b0);
      check("ab_we_lo", we_lo, 3);
      check("ab_nstr", nstr, 1);
      check("ab_ce_lo", ce_lo, 6);
      check("ab_ce_end", fsmc_ce_n, 1'b1);

      // Reset asserted during DATA of a read, between clock edges
      mon_clear();
      wbs_adr_i = 24'h000020; wbs_sel_i = 4'hF; wbs_we_i = 1'b0;
      wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("rr_oe_pre", fsmc_oe_n, 1'b0);
      #2;
      rst = 1'b0;
      #1;
      check("rr_strobes", {fsmc_ce_n, fsmc_we_n, fsmc_oe_n, fsmc_ub_n, fsmc_lb_n}, 5'b11111);
      check("rr_d_oe", fsmc_d_oe, 1'b0);
      check("rr_ack", wbs_ack_o, 1'b0);
      wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rr_idle_ce", fsmc_ce_n, 1'b1);
      check("rr_idle_ack", wbs_ack_o, 1'b0);

      // Next access after reset completes normally
      xfer(24'h000040, 32'h0BADF00D, 4'hF, 1'b1, 0);
      check("pr_lat", lat, 14);
      check("pr_a0", mon_a[0], 16'h0020);
      check("pr_d0", mon_d[0], 16'hF00D);
      check("pr_d1", mon_d[1], 16'h0BAD);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
